// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display path: active-high
// gfedcba patterns, the all-off pattern and a width helper.
package display_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
// Codes A-F are not decimal digits and render as a dash.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed scan of DIGITS BCD values onto one shared segment bus,
// with ghost blanking, leading-zero suppression, decimal points and frame pulse.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int COMMON_ANODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_blank,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CNT_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam int IDX_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Pin polarity: for common-anode boards every output is inverted, so the
  // "inactive" level at the pins is all ones.
  localparam logic POL = (COMMON_ANODE != 0);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                sh_lz_q, sh_lz_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                slot_start;
  logic                active;
  logic [DIGITS-1:0]   zero_above;
  logic [3:0]          sel_code;
  logic                sel_dp;
  logic                sel_hide;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   an_raw;
  logic                dp_raw;

  // zero_above[i] is set when digit i and every more-significant digit are 0;
  // invalid codes are non-zero, so they stop suppression.
  always_comb begin
    logic run;
    run        = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run           = run && (sh_digits_q[4*i +: 4] == 4'd0);
      zero_above[i] = run;
    end
  end

  always_comb begin
    sel_code = 4'd0;
    sel_dp   = 1'b0;
    sel_hide = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_code = sh_digits_q[4*i +: 4];
        sel_dp   = sh_dp_q[i];
        sel_hide = sh_lz_q && (i > 0) && zero_above[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .code (sel_code),
    .seg  (dec_seg)
  );

  always_comb begin
    slot_start  = (cnt_q == '0) && (idx_q == '0);
    active      = enable && (cnt_q >= BLANK_END);

    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_lz_d     = sh_lz_q;

    // Shadows only change at the top of a frame, so mid-frame input edits
    // never tear the displayed value.
    if (slot_start) begin
      sh_digits_d = digits;
      sh_dp_d     = dp_mask;
      sh_lz_d     = lz_blank;
    end

    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    an_raw  = '0;
    seg_raw = SEG_OFF;
    dp_raw  = 1'b0;
    if (active) begin
      an_raw  = DIGITS'(1) << idx_q;
      seg_raw = sel_hide ? SEG_OFF : dec_seg;
      dp_raw  = sel_dp;
    end

    an_d    = an_raw ^ {DIGITS{POL}};
    seg_d   = seg_raw ^ {7{POL}};
    dp_d    = dp_raw ^ POL;
    frame_d = enable && slot_start;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      seg_q       <= {7{POL}};
      dp_q        <= POL;
      an_q        <= {DIGITS{POL}};
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_lz_q     <= sh_lz_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: a common-cathode and a common-anode
// instance share the same stimulus and are checked against hand-computed values.
module tb_bcd_display_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic        enable;

  logic [6:0]  seg, seg_ca;
  logic        dp, dp_ca;
  logic [3:0]  an, an_ca;
  logic        frame, frame_ca;

  int n_checks;
  int n_fail;

  bcd_display_scan #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .COMMON_ANODE(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .lz_blank(lz_blank), .enable(enable),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  bcd_display_scan #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .COMMON_ANODE(1)
  ) u_dut_ca (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .lz_blank(lz_blank), .enable(enable),
    .seg(seg_ca), .dp(dp_ca), .an(an_ca), .frame(frame_ca)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected values are active-high; the common-anode instance must show the
  // same picture with an/seg/dp inverted and frame unchanged.
  task automatic check_now(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp,
                           input logic e_frame);
    logic [12:0] obs_v, exp_v;
    obs_v = {an, seg, dp, frame};
    exp_v = {e_an, e_seg, e_dp, e_frame};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: an/seg/dp/frame observed=%h expected=%h", tag, obs_v, exp_v);
    end
    obs_v = {an_ca, seg_ca, dp_ca, frame_ca};
    exp_v = {~e_an, ~e_seg, ~e_dp, e_frame};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s_ca: an/seg/dp/frame observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic check_ca(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    logic [11:0] obs_v, exp_v;
    obs_v = {an_ca, seg_ca, dp_ca};
    exp_v = {e_an, e_seg, e_dp};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: pin an/seg/dp observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // One digit slot: one blank cycle then three lit cycles.
  task automatic run_slot(input string tag, input logic first,
                          input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp);
    step();
    check_now({tag, "_blank"}, 4'b0000, 7'h00, 1'b0, first);
    repeat (3) begin
      step();
      check_now(tag, e_an, e_seg, e_dp, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    enable   = 1'b1;
    digits   = 16'h1234;
    dp_mask  = 4'b0000;
    lz_blank = 1'b0;

    step();
    check_now("reset", 4'b0000, 7'h00, 1'b0, 1'b0);
    step();
    step();
    check_now("reset_hold", 4'b0000, 7'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Scan of 1234: digit 0 (=4) first, then 3, 2, 1.
    run_slot("scan_d0", 1'b1, 4'b0001, 7'h66, 1'b0);
    run_slot("scan_d1", 1'b0, 4'b0010, 7'h4F, 1'b0);
    run_slot("scan_d2", 1'b0, 4'b0100, 7'h5B, 1'b0);
    run_slot("scan_d3", 1'b0, 4'b1000, 7'h06, 1'b0);

    // Leading-zero suppression of 0050.
    digits   = 16'h0050;
    lz_blank = 1'b1;
    run_slot("lz_d0", 1'b1, 4'b0001, 7'h3F, 1'b0);
    run_slot("lz_d1", 1'b0, 4'b0010, 7'h6D, 1'b0);
    run_slot("lz_d2", 1'b0, 4'b0100, 7'h00, 1'b0);
    run_slot("lz_d3", 1'b0, 4'b1000, 7'h00, 1'b0);

    // All zeros: only digit 0 stays lit.
    digits = 16'h0000;
    run_slot("lz0_d0", 1'b1, 4'b0001, 7'h3F, 1'b0);
    run_slot("lz0_d1", 1'b0, 4'b0010, 7'h00, 1'b0);
    run_slot("lz0_d2", 1'b0, 4'b0100, 7'h00, 1'b0);
    run_slot("lz0_d3", 1'b0, 4'b1000, 7'h00, 1'b0);

    // Invalid code C shows a dash and is non-zero; dp on a suppressed digit.
    digits  = 16'h00C7;
    dp_mask = 4'b1010;
    run_slot("inv_d0", 1'b1, 4'b0001, 7'h07, 1'b0);
    run_slot("inv_d1", 1'b0, 4'b0010, 7'h40, 1'b1);
    run_slot("inv_d2", 1'b0, 4'b0100, 7'h00, 1'b0);
    run_slot("inv_d3", 1'b0, 4'b1000, 7'h00, 1'b1);

    // Tearing: change digits during digit 1 of the frame.
    digits   = 16'h1234;
    dp_mask  = 4'b0000;
    lz_blank = 1'b0;
    run_slot("tear_d0", 1'b1, 4'b0001, 7'h66, 1'b0);
    step();
    check_now("tear_d1_blank", 4'b0000, 7'h00, 1'b0, 1'b0);
    digits = 16'h5678;
    repeat (3) begin
      step();
      check_now("tear_d1", 4'b0010, 7'h4F, 1'b0, 1'b0);
    end
    run_slot("tear_d2", 1'b0, 4'b0100, 7'h5B, 1'b0);
    run_slot("tear_d3", 1'b0, 4'b1000, 7'h06, 1'b0);
    run_slot("new_d0", 1'b1, 4'b0001, 7'h7F, 1'b0);
    run_slot("new_d1", 1'b0, 4'b0010, 7'h07, 1'b0);
    run_slot("new_d2", 1'b0, 4'b0100, 7'h7D, 1'b0);
    run_slot("new_d3", 1'b0, 4'b1000, 7'h6D, 1'b0);

    // enable low for 5 cycles after the first lit cycle of digit 0.
    step();
    check_now("en_blank", 4'b0000, 7'h00, 1'b0, 1'b1);
    step();
    check_now("en_lit", 4'b0001, 7'h7F, 1'b0, 1'b0);
    enable = 1'b0;
    repeat (5) begin
      step();
      check_now("en_off", 4'b0000, 7'h00, 1'b0, 1'b0);
    end
    enable = 1'b1;
    repeat (2) begin
      step();
      check_now("en_resume", 4'b0001, 7'h7F, 1'b0, 1'b0);
    end
    run_slot("en_d1", 1'b0, 4'b0010, 7'h07, 1'b0);
    run_slot("en_d2", 1'b0, 4'b0100, 7'h7D, 1'b0);
    run_slot("en_d3", 1'b0, 4'b1000, 7'h6D, 1'b0);

    // Common-anode pins with 0008, then reset mid-slot.
    digits = 16'h0008;
    step();
    check_now("ca_blank", 4'b0000, 7'h00, 1'b0, 1'b1);
    check_ca("ca_pin_blank", 4'b1111, 7'h7F, 1'b1);
    step();
    check_now("ca_d0", 4'b0001, 7'h7F, 1'b0, 1'b0);
    check_ca("ca_pin_d0", 4'b1110, 7'h00, 1'b1);
    rst_n = 1'b0;
    step();
    check_now("rst_mid", 4'b0000, 7'h00, 1'b0, 1'b0);
    check_ca("ca_pin_rst", 4'b1111, 7'h7F, 1'b1);
    rst_n = 1'b1;
    step();
    check_now("rst_restart", 4'b0000, 7'h00, 1'b0, 1'b1);
    step();
    check_now("rst_d0", 4'b0001, 7'h7F, 1'b0, 1'b0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
